mini_core_rf_sb: RTL and testbench
==================================

# mini_core_rf_sb

Parametrised register file for the mini core decode stage (Q101H→Q102H): configurable data width, register count and read-port count, with a per-register pending-write scoreboard. The scoreboard detects read-after-write hazards against in-flight writers and stalls issue. It replaces the fixed 2-read, 32×32 register file.

## Interface
Parameters:
- DATA_W, 32, register and data width in bits
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired to zero
- NUM_RD, 2, number of read ports
- ADDR_W, $clog2(NUM_REGS), register address width (derived)

Ports:
- Clock  in  1  core clock
- Rst  in  1  asynchronous, active-high reset
- ReadyQ102H  in  1  downstream may accept; low means all Q102H state holds
- FlushQ101H  in  1  pipeline flush; clears the scoreboard and bubbles Q102H
- RdValidQ101H  in  NUM_RD  per-port "source is used"
- RdAddrQ101H  in  NUM_RD*ADDR_W  per-port source address; port i is at [i*ADDR_W +: ADDR_W]
- WrIssueQ101H  in  1  instruction in Q101H will write RegDstQ101H
- RegDstQ101H  in  ADDR_W  destination of the issuing instruction
- PcQ101H, ImmediateQ101H  in  32 each  passthrough operands
- RegWrEnQ104H  in  1  writeback enable
- RegDstQ104H  in  ADDR_W  writeback address
- RegWrDataQ104H  in  DATA_W  writeback data
- HazardQ101H  out  1  combinational; issue is blocked this cycle
- ValidQ102H  out  1  Q102H holds a real instruction
- RdDataQ102H  out  NUM_RD*DATA_W  registered read data
- PcQ102H, ImmediateQ102H  out  32 each  registered passthrough

## Operation
- Storage is registers 1..NUM_REGS-1, each DATA_W bits. Writes to address 0 are ignored. Reads of address 0 return 0 and are never hazards.
- Write: on a rising edge with RegWrEnQ104H=1 and RegDstQ104H≠0, the register takes RegWrDataQ104H.
- Scoreboard: each register r has a 2-bit pending counter Cnt[r].
  - Issue fires when ReadyQ102H & ~HazardQ101H & ~FlushQ101H & WrIssueQ101H & RegDstQ101H≠0. It increments Cnt[RegDstQ101H].
  - A writeback to r≠0 decrements Cnt[r]. If Cnt[r]=0, the counter stays at 0 (untracked writer, no underflow).
  - Issue and writeback to the same register in the same cycle leave Cnt unchanged.
  - FlushQ101H=1 clears all Cnt to 0 and overrides any issue or writeback counter update. The data write itself still occurs.
- Hazard: HazardQ101H=1 if either condition holds:
  - Any port i has RdValidQ101H[i], addr≠0, and Cnt[addr]≠0, except when Cnt[addr]=1 and a same-cycle writeback to addr exists (forward case, see Configuration).
  - WrIssueQ101H & RegDstQ101H≠0 & Cnt[RegDstQ101H]=3 (counter saturation).
- Read data per port, in priority order:
  - address 0 → 0
  - same-cycle writeback match → RegWrDataQ104H
  - otherwise → stored value

## Timing
- Reset: all registers 0, all Cnt 0, ValidQ102H 0, RdDataQ102H 0, PcQ102H 0, ImmediateQ102H 0.
- Q102H update on each rising edge:
  - FlushQ101H=1 → ValidQ102H←0; data outputs hold.
  - Else ReadyQ102H=0 → all Q102H outputs hold.
  - Else HazardQ101H=1 → ValidQ102H←0 (bubble); data outputs hold.
  - Else → ValidQ102H←1; RdDataQ102H, PcQ102H, ImmediateQ102H capture their Q101H values.
- Read latency is 1 cycle, Q101H→Q102H.
- Without forwarding, a write is visible to reads in the cycle after its edge.
- Rst asserted mid-operation clears everything immediately. In-flight writers are not remembered after reset.

## Configuration
- MINI_CORE_RF_SB_FWD_EN defined: same-cycle Q104H→Q101H bypass on every read port. A Cnt=1 register being written this cycle is not a hazard.
- MINI_CORE_RF_SB_FWD_EN undefined: no bypass; reads always return the stored value. HazardQ101H asserts whenever Cnt[addr]≠0, including the cycle of the clearing writeback, so one extra stall cycle occurs.

## Test plan
- Reset, then read x5 on both ports, Ready=1 → next cycle ValidQ102H=1, RdDataQ102H={0,0}. Write x0=0xFFFF_FFFF, then read x0 → returns 0.
- Write x3=0x1234_5678 at Q104H while reading x3 in the same cycle → RdDataQ102H=0x1234_5678 with FWD_EN. Without FWD_EN, the same value returns on a read one cycle later.
- Issue a writer to x7, then read x7 on the next cycle → HazardQ101H=1 and ValidQ102H=0 each cycle until writeback. With FWD_EN, the hazard drops in the writeback cycle and the data equals the forwarded value.
- Issue three writers to x9, then attempt a fourth → fourth sees HazardQ101H=1 (Cnt=3). After one writeback, Cnt=2 and the fourth issues.
- Issue writers to x4 and x8, then FlushQ101H=1 → all Cnt=0, ValidQ102H=0. A subsequent read of x4 issues with no hazard.
- Hold ReadyQ102H=0 for 3 cycles while changing PcQ101H → PcQ102H and RdDataQ102H stay constant. An issue attempted while ReadyQ102H=0 does not increment Cnt.

Source files
------------

// File: rtl/mini_core_rf_sb.sv
// mini_core_rf_sb: decode-stage register file (Q101H read, Q102H registered
// output) with a per-register pending-write scoreboard that stalls issue on
// read-after-write hazards and on writer-counter saturation.
//
// Optional feature macro: MINI_CORE_RF_SB_FWD_EN
//   defined   -> same-cycle Q104H writeback is bypassed to every read port,
//                and a Cnt=1 source being written this cycle is not a hazard
//   undefined -> reads return stored values only; any pending writer stalls
//
// Ports:
//   Clock, Rst            core clock, asynchronous active-high reset
//   ReadyQ102H            downstream accept; low holds all Q102H state
//   FlushQ101H            clears scoreboard, bubbles Q102H
//   RdValidQ101H/RdAddrQ101H   per-port source use / address (packed)
//   WrIssueQ101H/RegDstQ101H   issuing instruction writes RegDstQ101H
//   PcQ101H/ImmediateQ101H     passthrough operands
//   RegWrEnQ104H/RegDstQ104H/RegWrDataQ104H  writeback
//   HazardQ101H           combinational issue block
//   ValidQ102H, RdDataQ102H, PcQ102H, ImmediateQ102H  registered Q102H stage
module mini_core_rf_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       Clock,
  input  logic                       Rst,
  input  logic                       ReadyQ102H,
  input  logic                       FlushQ101H,
  input  logic [NUM_RD-1:0]          RdValidQ101H,
  input  logic [NUM_RD*ADDR_W-1:0]   RdAddrQ101H,
  input  logic                       WrIssueQ101H,
  input  logic [ADDR_W-1:0]          RegDstQ101H,
  input  logic [31:0]                PcQ101H,
  input  logic [31:0]                ImmediateQ101H,
  input  logic                       RegWrEnQ104H,
  input  logic [ADDR_W-1:0]          RegDstQ104H,
  input  logic [DATA_W-1:0]          RegWrDataQ104H,
  output logic                       HazardQ101H,
  output logic                       ValidQ102H,
  output logic [NUM_RD*DATA_W-1:0]   RdDataQ102H,
  output logic [31:0]                PcQ102H,
  output logic [31:0]                ImmediateQ102H
);

  localparam int unsigned CNT_W   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(3);

  logic [DATA_W-1:0]   rf_q  [NUM_REGS];
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];

  logic                  wb_hit;
  logic                  hazard_c;
  logic                  issue_c;
  logic [ADDR_W-1:0]     src_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;

  // Writeback to a real register (x0 writes are dropped)
  assign wb_hit = RegWrEnQ104H && (RegDstQ104H != '0);

  // Source read mux and hazard detection
  always_comb begin
    hazard_c  = 1'b0;
    rd_data_c = '0;
    src_addr  = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      src_addr = RdAddrQ101H[i*ADDR_W +: ADDR_W];
      if (src_addr != '0) begin
`ifdef MINI_CORE_RF_SB_FWD_EN
        // A single pending writer that is retiring this cycle is covered by the bypass
        if (RdValidQ101H[i] && (cnt_q[src_addr] != '0) &&
            !((cnt_q[src_addr] == CNT_W'(1)) && wb_hit && (RegDstQ104H == src_addr)))
          hazard_c = 1'b1;
        if (wb_hit && (RegDstQ104H == src_addr))
          rd_data_c[i*DATA_W +: DATA_W] = RegWrDataQ104H;
        else
          rd_data_c[i*DATA_W +: DATA_W] = rf_q[src_addr];
`else
        if (RdValidQ101H[i] && (cnt_q[src_addr] != '0))
          hazard_c = 1'b1;
        rd_data_c[i*DATA_W +: DATA_W] = rf_q[src_addr];
`endif
      end
    end
    // A fourth in-flight writer to one register cannot be tracked
    if (WrIssueQ101H && (RegDstQ101H != '0) && (cnt_q[RegDstQ101H] == CNT_MAX))
      hazard_c = 1'b1;
  end

  assign HazardQ101H = hazard_c;
  assign issue_c     = ReadyQ102H && !hazard_c && !FlushQ101H &&
                       WrIssueQ101H && (RegDstQ101H != '0);

  // Next scoreboard counts; issue and writeback to the same register cancel
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_d[r] = cnt_q[r];
      if (FlushQ101H)
        cnt_d[r] = '0;
      else if (issue_c && (RegDstQ101H == ADDR_W'(r)) &&
               !(wb_hit && (RegDstQ104H == ADDR_W'(r))))
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (wb_hit && (RegDstQ104H == ADDR_W'(r)) &&
               !(issue_c && (RegDstQ101H == ADDR_W'(r))) && (cnt_q[r] != '0))
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
  end

  // Scoreboard counters
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Register storage; entry 0 is held at zero
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) rf_q[r] <= '0;
    end else if (wb_hit) begin
      rf_q[RegDstQ104H] <= RegWrDataQ104H;
    end
  end

  // Q102H stage: flush/hazard bubble, not-ready hold
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      ValidQ102H     <= 1'b0;
      RdDataQ102H    <= '0;
      PcQ102H        <= '0;
      ImmediateQ102H <= '0;
    end else if (FlushQ101H) begin
      ValidQ102H <= 1'b0;
    end else if (ReadyQ102H) begin
      if (hazard_c) begin
        ValidQ102H <= 1'b0;
      end else begin
        ValidQ102H     <= 1'b1;
        RdDataQ102H    <= rd_data_c;
        PcQ102H        <= PcQ101H;
        ImmediateQ102H <= ImmediateQ101H;
      end
    end
  end

endmodule

// File: tb/tb_mini_core_rf_sb.sv
// Scoreboard bench for mini_core_rf_sb with a behavioural reference model.
module tb_mini_core_rf_sb;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned AW  = 5;
`ifdef MINI_CORE_RF_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              Clock;
  logic              Rst;
  logic              ReadyQ102H;
  logic              FlushQ101H;
  logic [NRD-1:0]    RdValidQ101H;
  logic [NRD*AW-1:0] RdAddrQ101H;
  logic              WrIssueQ101H;
  logic [AW-1:0]     RegDstQ101H;
  logic [31:0]       PcQ101H;
  logic [31:0]       ImmediateQ101H;
  logic              RegWrEnQ104H;
  logic [AW-1:0]     RegDstQ104H;
  logic [DW-1:0]     RegWrDataQ104H;
  logic              HazardQ101H;
  logic              ValidQ102H;
  logic [NRD*DW-1:0] RdDataQ102H;
  logic [31:0]       PcQ102H;
  logic [31:0]       ImmediateQ102H;

  mini_core_rf_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .Clock(Clock), .Rst(Rst), .ReadyQ102H(ReadyQ102H), .FlushQ101H(FlushQ101H),
    .RdValidQ101H(RdValidQ101H), .RdAddrQ101H(RdAddrQ101H),
    .WrIssueQ101H(WrIssueQ101H), .RegDstQ101H(RegDstQ101H),
    .PcQ101H(PcQ101H), .ImmediateQ101H(ImmediateQ101H),
    .RegWrEnQ104H(RegWrEnQ104H), .RegDstQ104H(RegDstQ104H),
    .RegWrDataQ104H(RegWrDataQ104H), .HazardQ101H(HazardQ101H),
    .ValidQ102H(ValidQ102H), .RdDataQ102H(RdDataQ102H),
    .PcQ102H(PcQ102H), .ImmediateQ102H(ImmediateQ102H)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst, ready, flush;
    logic [1:0]  rdv;
    logic [4:0]  a0, a1;
    logic        wri;
    logic [4:0]  dst;
    logic [31:0] pc, imm;
    logic        wen;
    logic [4:0]  wdst;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] rd0, rd1, pc, imm;
    logic        hz;
  } exp_t;

  exp_t scb[$];

  // Reference model: architectural state as plain arrays and integers
  logic [31:0] m_rf  [NR];
  int          m_cnt [NR];
  logic        m_valid;
  logic [31:0] m_rd0, m_rd1, m_pc, m_imm;

  stim_t       p;
  logic        p_hz;
  logic [31:0] p_rd0, p_rd1;

  int n_chk, n_fail, n_push, n_pop;

  task automatic model_reset();
    for (int r = 0; r < int'(NR); r++) begin
      m_rf[r]  = '0;
      m_cnt[r] = 0;
    end
    m_valid = 1'b0; m_rd0 = '0; m_rd1 = '0; m_pc = '0; m_imm = '0;
  endtask

  function automatic logic src_blocked(logic v, logic [4:0] a, stim_t s);
    if (!v || a == 0) return 1'b0;
    if (m_cnt[a] == 0) return 1'b0;
    if (FWD && m_cnt[a] == 1 && s.wen && s.wdst == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_hazard(stim_t s);
    return src_blocked(s.rdv[0], s.a0, s) || src_blocked(s.rdv[1], s.a1, s) ||
           (s.wri && s.dst != 0 && m_cnt[s.dst] == 3);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a, stim_t s);
    if (a == 0) return '0;
    if (FWD && s.wen && s.wdst == a) return s.wdata;
    return m_rf[a];
  endfunction

  // Apply the effect of one rising edge using the previous cycle's inputs
  task automatic model_edge();
    logic issue, wbm;
    if (p.flush) m_valid = 1'b0;
    else if (p.ready) begin
      if (p_hz) m_valid = 1'b0;
      else begin
        m_valid = 1'b1; m_rd0 = p_rd0; m_rd1 = p_rd1; m_pc = p.pc; m_imm = p.imm;
      end
    end
    issue = p.ready && !p_hz && p.wri && p.dst != 0;
    wbm   = p.wen && p.wdst != 0;
    if (p.flush) begin
      for (int r = 0; r < int'(NR); r++) m_cnt[r] = 0;
    end else if (!(issue && wbm && p.dst == p.wdst)) begin
      if (issue) m_cnt[p.dst] = m_cnt[p.dst] + 1;
      if (wbm && m_cnt[p.wdst] > 0) m_cnt[p.wdst] = m_cnt[p.wdst] - 1;
    end
    if (wbm) m_rf[p.wdst] = p.wdata;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge Clock);
    if (!p.rst) model_edge();
    #1;
    Rst            = s.rst;
    ReadyQ102H     = s.ready;
    FlushQ101H     = s.flush;
    RdValidQ101H   = s.rdv;
    RdAddrQ101H    = {s.a1, s.a0};
    WrIssueQ101H   = s.wri;
    RegDstQ101H    = s.dst;
    PcQ101H        = s.pc;
    ImmediateQ101H = s.imm;
    RegWrEnQ104H   = s.wen;
    RegDstQ104H    = s.wdst;
    RegWrDataQ104H = s.wdata;
    if (s.rst) model_reset();
    p_hz  = m_hazard(s);
    p_rd0 = m_read(s.a0, s);
    p_rd1 = m_read(s.a1, s);
    e.valid = m_valid; e.rd0 = m_rd0; e.rd1 = m_rd1; e.pc = m_pc; e.imm = m_imm; e.hz = p_hz;
    scb.push_back(e);
    n_push++;
    p = s;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.ready = 1'b1;
    return s;
  endfunction

  function automatic logic [4:0] pick();
    logic [4:0] hot [6];
    hot = '{5'd0, 5'd3, 5'd4, 5'd7, 5'd8, 5'd9};
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return hot[$urandom_range(0, 5)];
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst   = 1'b0;
    s.ready = ($urandom_range(0, 9) < 8);
    s.flush = ($urandom_range(0, 29) == 0);
    s.rdv   = 2'($urandom);
    s.a0    = pick();
    s.a1    = pick();
    s.wri   = 1'($urandom);
    s.dst   = pick();
    s.pc    = $urandom;
    s.imm   = $urandom;
    s.wen   = ($urandom_range(0, 9) < 4);
    s.wdst  = pick();
    s.wdata = $urandom;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: each cycle's Q102H outputs and Q101H hazard against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        n_pop++;
        chk("hazard", 32'(HazardQ101H), 32'(e.hz));
        chk("valid",  32'(ValidQ102H),  32'(e.valid));
        chk("rdata0", RdDataQ102H[31:0],  e.rd0);
        chk("rdata1", RdDataQ102H[63:32], e.rd1);
        chk("pc",     PcQ102H,        e.pc);
        chk("imm",    ImmediateQ102H, e.imm);
      end
    end
  end

  initial begin
    stim_t s;
    n_chk = 0; n_fail = 0; n_push = 0; n_pop = 0;
    s = idle();
    s.rst = 1'b1;
    p = s; p_hz = 1'b0; p_rd0 = '0; p_rd1 = '0;
    model_reset();
    Rst = 1'b1; ReadyQ102H = 1'b0; FlushQ101H = 1'b0; RdValidQ101H = '0;
    RdAddrQ101H = '0; WrIssueQ101H = 1'b0; RegDstQ101H = '0; PcQ101H = '0;
    ImmediateQ101H = '0; RegWrEnQ104H = 1'b0; RegDstQ104H = '0; RegWrDataQ104H = '0;
    drive(s);

    // Reads of x5 after reset, then x0 write is ignored
    s = idle(); s.rdv = 2'b11; s.a0 = 5'd5; s.a1 = 5'd5; s.pc = 32'h100; drive(s);
    s = idle(); s.wen = 1'b1; s.wdst = 5'd0; s.wdata = 32'hFFFF_FFFF; drive(s);
    s = idle(); s.rdv = 2'b11; drive(s);
    // Same-cycle write/read of x3, then a later read
    s = idle(); s.wen = 1'b1; s.wdst = 5'd3; s.wdata = 32'h1234_5678;
    s.rdv = 2'b11; s.a0 = 5'd3; s.a1 = 5'd3; drive(s);
    s = idle(); s.rdv = 2'b11; s.a0 = 5'd3; s.a1 = 5'd3; drive(s);
    // Writer to x7 stalls readers until its writeback
    s = idle(); s.wri = 1'b1; s.dst = 5'd7; drive(s);
    repeat (3) begin s = idle(); s.rdv = 2'b01; s.a0 = 5'd7; drive(s); end
    s.wen = 1'b1; s.wdst = 5'd7; s.wdata = 32'hCAFE_0007; drive(s);
    s = idle(); s.rdv = 2'b01; s.a0 = 5'd7; drive(s); drive(s);
    // Saturation on x9
    repeat (4) begin s = idle(); s.wri = 1'b1; s.dst = 5'd9; drive(s); end
    s.wen = 1'b1; s.wdst = 5'd9; s.wdata = 32'h9; drive(s);
    s = idle(); s.wri = 1'b1; s.dst = 5'd9; drive(s);
    repeat (3) begin s = idle(); s.wen = 1'b1; s.wdst = 5'd9; s.wdata = 32'h99; drive(s); end
    // Flush clears pending writers
    s = idle(); s.wri = 1'b1; s.dst = 5'd4; drive(s);
    s = idle(); s.wri = 1'b1; s.dst = 5'd8; drive(s);
    s = idle(); s.flush = 1'b1; s.wri = 1'b1; s.dst = 5'd4; drive(s);
    s = idle(); s.rdv = 2'b01; s.a0 = 5'd4; s.pc = 32'h444; drive(s);
    // Not-ready hold; issue while stalled must not count
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.ready = 1'b0; s.pc = 32'h200 + 32'(k); s.rdv = 2'b11;
      s.a0 = 5'd3; s.a1 = 5'd7; s.wri = 1'b1; s.dst = 5'd10; drive(s);
    end
    s = idle(); s.rdv = 2'b01; s.a0 = 5'd10; s.pc = 32'h300; drive(s);

    // Randomized traffic with a mid-run asynchronous reset
    repeat (1500) drive(rnd());
    s = rnd(); s.rst = 1'b1; drive(s);
    s = rnd(); s.rst = 1'b1; drive(s);
    repeat (1500) drive(rnd());

    for (int t = 0; t < 10 && scb.size() > 0; t++) @(posedge Clock);
    @(negedge Clock);
    #1;
    chk("drained", 32'(n_pop), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
